// File: rtl/rip_fifo_read_serializer.sv
// Drains words from a first-word-fall-through FIFO and emits each one as
// DATA_WIDTH/OUT_WIDTH valid/ready beats, least-significant slice first.
module rip_fifo_read_serializer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic [31:0]           word_count
);

  localparam int unsigned Ratio = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  if ((OUT_WIDTH == 0) || (DATA_WIDTH % OUT_WIDTH != 0)) begin : gen_width_check
    $error("DATA_WIDTH must be a non-zero integer multiple of OUT_WIDTH");
  end

  typedef enum logic {StIdle, StSend} state_e;

  state_e                            state_q;
  logic [Ratio-1:0][OUT_WIDTH-1:0]   buffer_q;
  logic [BeatW-1:0]                  beat_q;
  logic [31:0]                       word_count_q;
  logic [OUT_WIDTH-1:0]              slice;

  if (Ratio == 1) begin : gen_single_slice
    assign slice = buffer_q[0];
  end else begin : gen_multi_slice
    assign slice = buffer_q[beat_q];
  end

  always_comb begin
    m_valid    = (state_q == StSend);
    m_last     = m_valid && (beat_q == LastBeat);
    m_data     = slice;
    word_count = word_count_q;
    // A pop is only requested when idle or while the last beat is leaving,
    // which keeps consecutive words gap-free. Gated by reset so nothing is
    // popped while the block is held in reset.
    fifo_r_en  = rst_n && !fifo_empty &&
                 ((state_q == StIdle) || (m_ready && m_last));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      buffer_q     <= '0;
      beat_q       <= '0;
      word_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fifo_r_en) begin
            buffer_q <= fifo_data;
            beat_q   <= '0;
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (m_ready) begin
            if (m_last) begin
              word_count_q <= word_count_q + 32'd1;
              if (fifo_r_en) begin
                buffer_q <= fifo_data;
                beat_q   <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              beat_q <= beat_q + BeatW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_fifo_read_serializer.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks
// every presented beat; cycle-level timing is checked from recorded cycle lists.
module tb_rip_fifo_read_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         fifo_empty = 1'b1, fifo_empty_r1 = 1'b1;
  logic [127:0] fifo_data = '0, fifo_data_r1 = '0;
  logic         fifo_r_en, fifo_r_en_r1;
  logic         m_valid, m_valid_r1, m_last, m_last_r1;
  logic         m_ready = 1'b1, m_ready_r1 = 1'b1;
  logic [31:0]  m_data;
  logic [127:0] m_data_r1;
  logic [31:0]  word_count, word_count_r1;

  rip_fifo_read_serializer #(.DATA_WIDTH(128), .OUT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .word_count(word_count)
  );

  rip_fifo_read_serializer #(.DATA_WIDTH(128), .OUT_WIDTH(128)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_r1), .fifo_data(fifo_data_r1),
    .fifo_r_en(fifo_r_en_r1), .m_valid(m_valid_r1), .m_ready(m_ready_r1),
    .m_data(m_data_r1), .m_last(m_last_r1), .word_count(word_count_r1)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t        exp0[$], exp1[$];
  logic [127:0] fq0[$], fq1[$];
  int           rden0[$], vld0[$], acc0[$], stall0[$], rden1[$], acc1[$];
  int           e[$];
  int           cyc = 0, tests = 0, fails = 0, viol = 0;
  bit           pop0 = 1'b0, pop1 = 1'b0;

  localparam logic [127:0] WordA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] WordB = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] WordC = 128'hC0C0C0C0_0000000C_DEADBEEF_00000001;
  localparam logic [127:0] WordD = 128'hD1D1D1D1_0000000D_CAFEF00D_00000002;
  localparam logic [127:0] WordE = 128'hE2E2E2E2_0000000E_0BADF00D_00000003;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_cyc(input string name, input int act[$]);
    tests++;
    if (act.size() != e.size()) begin
      fails++;
      $display("FAIL %s: got %0d cycles, expected %0d", name, act.size(), e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        if (act[i] != e[i]) begin
          fails++;
          $display("FAIL %s: entry %0d at cycle %0d, expected %0d", name, i, act[i], e[i]);
          break;
        end
      end
    end
  endtask

  task automatic add_run(input int start, input int n);
    for (int i = 0; i < n; i++) e.push_back(start + i);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rden0.delete(); vld0.delete(); acc0.delete(); stall0.delete();
    rden1.delete(); acc1.delete(); e.delete();
  endtask

  task automatic push0(input logic [127:0] w);
    beat_t b;
    fq0.push_back(w);
    for (int i = 0; i < 4; i++) begin
      b.data = {96'd0, w[i*32 +: 32]};
      b.last = (i == 3);
      exp0.push_back(b);
    end
  endtask

  task automatic push1(input logic [127:0] w);
    beat_t b;
    fq1.push_back(w);
    b.data = w;
    b.last = 1'b1;
    exp1.push_back(b);
  endtask

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO models: pop at the edge, present the new head shortly after.
  always @(posedge clk) begin
    if (pop0) fq0.delete(0);
    if (pop1) fq1.delete(0);
    #2;
    fifo_empty    = (fq0.size() == 0);
    fifo_data     = fifo_empty ? '0 : fq0[0];
    fifo_empty_r1 = (fq1.size() == 0);
    fifo_data_r1  = fifo_empty_r1 ? '0 : fq1[0];
  end

  always @(negedge clk) begin
    pop0 = fifo_r_en && !fifo_empty;
    pop1 = fifo_r_en_r1 && !fifo_empty_r1;
    if (fifo_r_en) rden0.push_back(cyc);
    if (fifo_r_en_r1) rden1.push_back(cyc);
    if ((fifo_r_en && fifo_empty) || (fifo_r_en_r1 && fifo_empty_r1)) viol++;
    if (m_valid) begin
      vld0.push_back(cyc);
      if (exp0.size() == 0) begin
        tests++; fails++;
        $display("FAIL beat_unexpected: got %0h, expected no beat", m_data);
      end else begin
        chk("beat_data", {96'd0, m_data}, exp0[0].data);
        chk("beat_last", m_last, exp0[0].last);
        if (m_ready) begin
          acc0.push_back(cyc);
          exp0.delete(0);
        end else begin
          stall0.push_back(cyc);
        end
      end
    end
    if (m_valid_r1) begin
      if (exp1.size() == 0) begin
        tests++; fails++;
        $display("FAIL r1_beat_unexpected: got %0h, expected no beat", m_data_r1);
      end else begin
        chk("r1_beat_data", m_data_r1, exp1[0].data);
        chk("r1_beat_last", m_last_r1, exp1[0].last);
        if (m_ready_r1) begin
          acc1.push_back(cyc);
          exp1.delete(0);
        end
      end
    end
  end

  initial begin
    int p;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ren", fifo_r_en, 0);
    chk("rst_count", word_count, 0);
    chk("rst_r1_valid", m_valid_r1, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Single word with the consumer always ready.
    clear_rec(); push0(WordA); tick(8);
    p = first(rden0);
    e.push_back(p); chk_cyc("single_ren", rden0);
    e.delete(); add_run(p + 1, 4); chk_cyc("single_beats", acc0);
    chk_cyc("single_valid", vld0);
    chk("single_count", word_count, 1);

    // Back-to-back words: no bubble, B popped during A's last beat.
    clear_rec(); push0(WordA); push0(WordB); tick(12);
    p = first(rden0);
    e.push_back(p); e.push_back(p + 4); chk_cyc("b2b_ren", rden0);
    e.delete(); add_run(p + 1, 8); chk_cyc("b2b_beats", acc0);
    chk_cyc("b2b_valid", vld0);
    chk("b2b_count", word_count, 3);

    // Backpressure for three cycles while beat 2 is presented.
    clear_rec(); push0(WordA); tick(3);
    m_ready = 1'b0; tick(3);
    m_ready = 1'b1; tick(6);
    p = first(rden0);
    e.push_back(p); chk_cyc("bp_ren", rden0);
    e.delete(); add_run(p + 1, 2); add_run(p + 6, 2); chk_cyc("bp_beats", acc0);
    e.delete(); add_run(p + 3, 3); chk_cyc("bp_stalls", stall0);
    chk("bp_count", word_count, 4);

    // FIFO empty at the word boundary; next word arrives five cycles later.
    clear_rec(); push0(WordA); tick(9); push0(WordB); tick(8);
    p = first(rden0);
    e.push_back(p); e.push_back(p + 9); chk_cyc("gap_ren", rden0);
    e.delete(); add_run(p + 1, 4); add_run(p + 10, 4); chk_cyc("gap_beats", acc0);
    chk_cyc("gap_valid", vld0);
    chk("gap_count", word_count, 6);

    // Asynchronous reset while beat 1 is on the bus.
    clear_rec(); push0(WordA); tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_last", m_last, 0);
    chk("midrst_ren", fifo_r_en, 0);
    chk("midrst_count", word_count, 0);
    exp0.delete();
    tick(2);
    rst_n = 1'b1;
    clear_rec(); tick(6);
    chk("postrst_ren", rden0.size(), 0);
    chk("postrst_valid", vld0.size(), 0);

    // RATIO=1 instance: every beat is last, one pop per cycle.
    clear_rec(); push1(WordC); push1(WordD); push1(WordE); tick(6);
    p = first(rden1);
    add_run(p, 3); chk_cyc("r1_ren", rden1);
    e.delete(); add_run(p + 1, 3); chk_cyc("r1_beats", acc1);
    chk("r1_count", word_count_r1, 3);

    chk("ren_while_empty", viol, 0);
    chk("sb_drained", exp0.size(), 0);
    chk("r1_sb_drained", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
